// File: rtl/alu_pkg.sv
// Shared constants for the parameterised ALU: opcode/funct encodings, internal
// select codes, FSM states and the alu_op/funct decoder.
package alu_pkg;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  typedef enum logic [3:0] {
    SEL_AND   = 4'b0000,
    SEL_OR    = 4'b0001,
    SEL_ADD   = 4'b0010,
    SEL_SUB   = 4'b0011,
    SEL_SLT   = 4'b0100,
    SEL_SLL   = 4'b0101,
    SEL_SRL   = 4'b0110,
    SEL_SRA   = 4'b0111,
    SEL_SLLV  = 4'b1000,
    SEL_SRLV  = 4'b1001,
    SEL_SRAV  = 4'b1010,
    SEL_MULT  = 4'b1011,
    SEL_SLTU  = 4'b1100,
    SEL_MULTU = 4'b1101,
    SEL_MFHI  = 4'b1110,
    SEL_MFLO  = 4'b1111
  } alu_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_MUL_RUN = 2'b01,
    ST_FINISH  = 2'b10
  } state_e;

  typedef struct packed {
    alu_sel_e sel;
    logic     illegal;
  } dec_t;

  function automatic dec_t decode(input logic [1:0] op, input logic [5:0] fn);
    dec_t d;
    d.sel     = SEL_AND;
    d.illegal = 1'b0;
    case (op)
      OP_ADD: d.sel = SEL_ADD;
      OP_SUB: d.sel = SEL_SUB;
      OP_RTYPE: begin
        case (fn)
          F_AND:   d.sel = SEL_AND;
          F_OR:    d.sel = SEL_OR;
          F_ADD:   d.sel = SEL_ADD;
          F_SUB:   d.sel = SEL_SUB;
          F_SLT:   d.sel = SEL_SLT;
          F_SLTU:  d.sel = SEL_SLTU;
          F_SLL:   d.sel = SEL_SLL;
          F_SRL:   d.sel = SEL_SRL;
          F_SRA:   d.sel = SEL_SRA;
          F_SLLV:  d.sel = SEL_SLLV;
          F_SRLV:  d.sel = SEL_SRLV;
          F_SRAV:  d.sel = SEL_SRAV;
          F_MULT:  d.sel = SEL_MULT;
          F_MULTU: d.sel = SEL_MULTU;
          F_MFHI:  d.sel = SEL_MFHI;
          F_MFLO:  d.sel = SEL_MFLO;
          default: d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational datapath: logic, arithmetic, compares and shifts.
// Multiply and HI/LO moves are handled by the enclosing unit.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]               sel,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [$clog2(WIDTH)-1:0] sh,
  output logic [WIDTH-1:0]         y
);

  // NOTE: y gets a default before the case so every select path assigns it and no latch is inferred.
  always_comb begin
    y = '0;
    case (sel)
      SEL_AND:            y = a & b;
      SEL_OR:             y = a | b;
      SEL_ADD:            y = a + b;
      SEL_SUB:            y = a - b;
      SEL_SLT:            y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      SEL_SLTU:           y = {{(WIDTH-1){1'b0}}, (a < b)};
      SEL_SLL, SEL_SLLV:  y = b << sh;
      SEL_SRL, SEL_SRLV:  y = b >> sh;
      SEL_SRA, SEL_SRAV:  y = $signed(b) >>> sh;
      default:            y = '0;
    endcase
  end

endmodule

// File: rtl/param_alu_unit.sv
// Multi-cycle ALU: decode and operand capture on start, single-cycle ops through
// alu_core, signed/unsigned multiply by iterative shift-add into HI/LO.
module param_alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MUL_CYC_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               alu_op,
  input  logic [5:0]               funct,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic [WIDTH-1:0]         result,
  output logic                     zero,
  output logic [WIDTH-1:0]         hi,
  output logic [WIDTH-1:0]         lo,
  output logic                     busy,
  output logic                     done,
  output logic                     illegal
);

  localparam int SH_W = $clog2(WIDTH);

  state_e               state_q, state_d;
  alu_sel_e             sel_q;
  logic                 ill_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [SH_W-1:0]      sh_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic                 neg_q;
  logic [MUL_CYC_W-1:0] cnt_q;
  logic [WIDTH-1:0]     result_q, hi_q, lo_q;
  logic                 zero_q, done_q, illegal_q;

  dec_t             dec;
  logic             dec_mul, dec_signed, dec_var_sh, last_iter, mul_q;
  logic [WIDTH-1:0] mag_a, mag_b, core_y, single_res;
  logic [WIDTH:0]   add_sum;
  logic [2*WIDTH-1:0] prod_step, prod_fin;

  assign dec        = decode(alu_op, funct);
  assign dec_signed = (dec.sel == SEL_MULT);
  assign dec_mul    = dec_signed || (dec.sel == SEL_MULTU);
  assign dec_var_sh = (dec.sel == SEL_SLLV) || (dec.sel == SEL_SRLV) || (dec.sel == SEL_SRAV);
  assign mag_a      = (dec_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b      = (dec_signed && b[WIDTH-1]) ? -b : b;
  assign mul_q      = (sel_q == SEL_MULT) || (sel_q == SEL_MULTU);
  assign last_iter  = (cnt_q == MUL_CYC_W'(WIDTH - 1));

  // Upper half accumulates the multiplicand when the low bit of the shifting multiplier is set.
  assign add_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q & {WIDTH{prod_q[0]}}};
  assign prod_step = {add_sum, prod_q[WIDTH-1:1]};
  assign prod_fin  = neg_q ? -prod_q : prod_q;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .sel (sel_q),
    .a   (a_q),
    .b   (b_q),
    .sh  (sh_q),
    .y   (core_y)
  );

  always_comb begin
    single_res = core_y;
    if (ill_q)                  single_res = '0;
    else if (sel_q == SEL_MFHI) single_res = hi_q;
    else if (sel_q == SEL_MFLO) single_res = lo_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = dec_mul ? ST_MUL_RUN : ST_FINISH;
      ST_MUL_RUN: if (last_iter) state_d = ST_FINISH;
      ST_FINISH:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential blocks use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: operand/product capture registers are loaded on every accepted start, so only architectural state is reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && start && !rst) begin
      sel_q   <= dec.sel;
      ill_q   <= dec.illegal;
      a_q     <= a;
      b_q     <= b;
      sh_q    <= dec_var_sh ? a[SH_W-1:0] : shamt;
      mcand_q <= mag_a;
      prod_q  <= {{WIDTH{1'b0}}, mag_b};
      neg_q   <= dec_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (state_q == ST_MUL_RUN) begin
      prod_q  <= prod_step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        ST_IDLE:    if (start) cnt_q <= '0;
        ST_MUL_RUN: cnt_q <= cnt_q + 1'b1;
        ST_FINISH: begin
          done_q    <= 1'b1;
          illegal_q <= ill_q;
          if (mul_q) begin
            hi_q     <= prod_fin[2*WIDTH-1:WIDTH];
            lo_q     <= prod_fin[WIDTH-1:0];
            result_q <= prod_fin[WIDTH-1:0];
            zero_q   <= (prod_fin[WIDTH-1:0] == '0);
          end else begin
            result_q <= single_res;
            zero_q   <= (single_res == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign result  = result_q;
  assign zero    = zero_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_param_alu_unit.sv
// Directed-vector bench for param_alu_unit at WIDTH=32 with hand-computed results.
module tb_param_alu_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  alu_op = 2'b00;
  logic [5:0]  funct = 6'b0;
  logic [4:0]  shamt = 5'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] result, hi, lo;
  logic        zero, busy, done, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  param_alu_unit #(.WIDTH(32), .MUL_CYC_W(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .alu_op  (alu_op),
    .funct   (funct),
    .shamt   (shamt),
    .a       (a),
    .b       (b),
    .result  (result),
    .zero    (zero),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; start is seen at the next posedge, inputs are then scrambled.
  task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] av, input logic [31:0] bv, input logic [4:0] sh);
    alu_op = op; funct = fn; a = av; b = bv; shamt = sh; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; alu_op = OP_RTYPE; funct = F_OR; shamt = 5'd31;
  endtask

  // Returns edges from the accepting edge to done, and how many sampled cycles had busy high.
  task automatic wait_done(input int poke_at, output int edges, output int busy_cycles);
    edges = 1;
    busy_cycles = 0;
    while (!done && edges < 200) begin
      if (busy) busy_cycles++;
      if (edges == poke_at) begin
        start = 1'b1; alu_op = OP_ADD; a = 32'd2; b = 32'd3;
      end else if (edges == poke_at + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    if (!done) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_single(input string tag, input logic [1:0] op, input logic [5:0] fn,
                            input logic [31:0] av, input logic [31:0] bv, input logic [4:0] sh,
                            input logic [31:0] exp_res);
    int edges, bc;
    issue(op, fn, av, bv, sh);
    wait_done(-1, edges, bc);
    check({tag, "_lat"}, 64'(edges), 64'd2);
    check(tag, {32'd0, result}, {32'd0, exp_res});
    check({tag, "_zero"}, {63'd0, zero}, {63'd0, exp_res == 32'd0});
  endtask

  initial begin
    int edges, bc, dcount;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_result",  {32'd0, result}, 64'd0);
    check("rst_zero",    {63'd0, zero}, 64'd1);
    check("rst_hilo",    {hi, lo}, 64'd0);
    check("rst_busy",    {62'd0, busy, done}, 64'd0);
    check("rst_illegal", {63'd0, illegal}, 64'd0);

    issue(OP_ADD, 6'd0, 32'd5, 32'd7, 5'd0);
    wait_done(-1, edges, bc);
    check("add_lat",     64'(edges), 64'd2);
    check("add_result",  {32'd0, result}, 64'd12);
    check("add_zero",    {63'd0, zero}, 64'd0);
    check("add_illegal", {63'd0, illegal}, 64'd0);
    check("add_busy_at_done", {63'd0, busy}, 64'd0);

    run_single("beq_sub", OP_SUB, 6'd0, 32'h1234, 32'h1234, 5'd0, 32'd0);
    run_single("slt",   OP_RTYPE, F_SLT,  32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1);
    run_single("sltu",  OP_RTYPE, F_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0);
    run_single("add_wrap", OP_RTYPE, F_ADD, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0);
    run_single("sub_wrap", OP_RTYPE, F_SUB, 32'd0, 32'd1, 5'd0, 32'hFFFF_FFFF);
    run_single("and",   OP_RTYPE, F_AND,  32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd0, 32'h00F0_F000);
    run_single("or",    OP_RTYPE, F_OR,   32'hF000_0001, 32'h0000_0F00, 5'd0, 32'hF000_0F01);
    run_single("sll",   OP_RTYPE, F_SLL,  32'd0, 32'd1, 5'd4, 32'd16);
    run_single("srl",   OP_RTYPE, F_SRL,  32'd0, 32'h8000_0000, 5'd31, 32'd1);
    run_single("sra",   OP_RTYPE, F_SRA,  32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000);
    run_single("sllv",  OP_RTYPE, F_SLLV, 32'h0000_0023, 32'd1, 5'd0, 32'd8);
    run_single("srlv",  OP_RTYPE, F_SRLV, 32'd4, 32'h8000_0000, 5'd0, 32'h0800_0000);
    run_single("srav",  OP_RTYPE, F_SRAV, 32'd8, 32'h8000_0000, 5'd0, 32'hFF80_0000);

    // Signed multiply -2 * 3, then MFHI/MFLO back to back from the done cycle.
    issue(OP_RTYPE, F_MULT, 32'hFFFF_FFFE, 32'd3, 5'd0);
    wait_done(-1, edges, bc);
    check("mult_lat",    64'(edges), 64'd34);
    check("mult_busy",   64'(bc), 64'd33);
    check("mult_hilo",   {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    check("mult_result", {32'd0, result}, 64'h0000_0000_FFFF_FFFA);
    run_single("mfhi", OP_RTYPE, F_MFHI, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF);
    run_single("mflo", OP_RTYPE, F_MFLO, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFA);

    // Most-negative operands.
    issue(OP_RTYPE, F_MULT, 32'h8000_0000, 32'h8000_0000, 5'd0);
    wait_done(-1, edges, bc);
    check("mult_minmin", {hi, lo}, 64'h4000_0000_0000_0000);
    issue(OP_RTYPE, F_MULT, 32'h8000_0000, 32'd1, 5'd0);
    wait_done(-1, edges, bc);
    check("mult_min1",   {hi, lo}, 64'hFFFF_FFFF_8000_0000);
    issue(OP_RTYPE, F_MULT, 32'd7, 32'hFFFF_FFFB, 5'd0);
    wait_done(-1, edges, bc);
    check("mult_pos_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFDD);

    // Unsigned multiply with an ignored start pulse mid-run.
    issue(OP_RTYPE, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    wait_done(5, edges, bc);
    check("multu_lat",  64'(edges), 64'd34);
    check("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);
    check("multu_no_requeue", {62'd0, busy, done}, 64'd0);

    // Illegal decodes leave HI/LO alone.
    issue(OP_RTYPE, 6'b111111, 32'd9, 32'd9, 5'd0);
    wait_done(-1, edges, bc);
    check("ill_lat",     64'(edges), 64'd2);
    check("ill_flag",    {63'd0, illegal}, 64'd1);
    check("ill_result",  {32'd0, result}, 64'd0);
    check("ill_hilo",    {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    issue(OP_ILL, F_ADD, 32'd9, 32'd9, 5'd0);
    wait_done(-1, edges, bc);
    check("ill_op11",    {31'd0, illegal, result}, 64'h1_0000_0000);
    run_single("legal_after_ill", OP_ADD, 6'd0, 32'd1, 32'd1, 5'd0, 32'd2);
    check("ill_cleared", {63'd0, illegal}, 64'd0);

    // Reset ten cycles into a multiply.
    issue(OP_RTYPE, F_MULT, 32'd7, 32'd9, 5'd0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", {62'd0, busy, done}, 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("rst_mid_no_done", 64'(dcount), 64'd0);
    run_single("add_after_rst", OP_ADD, 6'd0, 32'd5, 32'd7, 5'd0, 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
